// File: rtl/amb_pkg.sv
// Shared types and elaboration-time geometry helpers for the LED zone averager.
// Window origins are computed here so that every window bound is a constant.
package amb_pkg;

    localparam int AMB_COLOR_W = 8;

    typedef struct packed {
        logic [AMB_COLOR_W-1:0] r;
        logic [AMB_COLOR_W-1:0] g;
        logic [AMB_COLOR_W-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
    } win_org_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } out_state_t;

    function automatic int num_leds(input int num_h, input int num_v);
        return num_h + 2 * num_v - 2;
    endfunction

    // Corner LEDs sit in the frame corners; interior LEDs are centred on their zone.
    function automatic int edge_origin(input int p, input int n, input int len, input int win);
        int pix;
        int c;
        pix = len / n;
        if (p == 0) return 0;
        if (p == n - 1) return len - win;
        c = p * pix + pix / 2 - win / 2;
        if (c < 0) c = 0;
        if (c > len - win) c = len - win;
        return c;
    endfunction

    function automatic win_org_t win_origin(input int idx, input int h_pix, input int v_pix,
                                            input int num_h, input int num_v, input int win);
        win_org_t o;
        if (idx < num_v) begin
            o.x = 16'd0;
            o.y = 16'(edge_origin(num_v - 1 - idx, num_v, v_pix, win));
        end else if (idx < num_v + num_h - 1) begin
            o.x = 16'(edge_origin(idx - (num_v - 1), num_h, h_pix, win));
            o.y = 16'd0;
        end else begin
            o.x = 16'(h_pix - win);
            o.y = 16'(edge_origin(idx - (num_v + num_h - 2), num_v, v_pix, win));
        end
        return o;
    endfunction

endpackage

// File: rtl/led_stream_out.sv
// Frame snapshot, optional IIR smoothing and valid/ready emission of per-LED colours.
// state   | meaning
// IDLE    | waiting for frame end; snapshot taken on entry to LOAD
// LOAD    | compute smoothed colour for r_cur, register outputs, update history
// SEND    | led_valid high, outputs held until handshake
module led_stream_out
    import amb_pkg::*;
#(
    parameter int NUM_LEDS     = 6,
    parameter int COLOR_W      = 8,
    parameter int SMOOTH_SHIFT = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_frame_end,
    input  logic [NUM_LEDS*3*COLOR_W-1:0] i_avgs,
    input  logic                          i_led_ready,
    output logic [3*COLOR_W-1:0]          o_led_rgb,
    output logic [7:0]                    o_led_idx,
    output logic                          o_led_last,
    output logic                          o_led_valid,
    output logic [15:0]                   o_frames_dropped
);

    localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);

    out_state_t               r_state;
    logic [IDX_W-1:0]         r_cur;
    logic [COLOR_W-1:0]       r_buf   [NUM_LEDS][3];
    logic [COLOR_W-1:0]       r_s_old [NUM_LEDS][3];
    logic signed [COLOR_W:0]  w_diff  [3];
    logic signed [COLOR_W:0]  w_res   [3];
    logic [COLOR_W-1:0]       w_new   [3];

    // Signed one-bit-wider arithmetic keeps the step toward the target exact.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            w_diff[c] = $signed({1'b0, r_buf[r_cur][c]}) - $signed({1'b0, r_s_old[r_cur][c]});
            w_res[c]  = $signed({1'b0, r_s_old[r_cur][c]}) + (w_diff[c] >>> SMOOTH_SHIFT);
            w_new[c]  = w_res[c][COLOR_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_cur            <= '0;
            o_led_rgb        <= '0;
            o_led_idx        <= '0;
            o_led_last       <= 1'b0;
            o_led_valid      <= 1'b0;
            o_frames_dropped <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                for (int c = 0; c < 3; c++) begin
                    r_buf[i][c]   <= '0;
                    r_s_old[i][c] <= '0;
                end
            end
        end else begin
            if (i_frame_end && (r_state != ST_IDLE) && (o_frames_dropped != 16'hFFFF)) begin
                o_frames_dropped <= o_frames_dropped + 16'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_frame_end) begin
                        for (int i = 0; i < NUM_LEDS; i++) begin
                            for (int c = 0; c < 3; c++) begin
                                r_buf[i][c] <= i_avgs[(i*3+c)*COLOR_W +: COLOR_W];
                            end
                        end
                        r_cur   <= '0;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    o_led_rgb   <= {w_new[0], w_new[1], w_new[2]};
                    o_led_idx   <= 8'(r_cur);
                    o_led_last  <= (r_cur == LAST_IDX);
                    o_led_valid <= 1'b1;
                    for (int c = 0; c < 3; c++) begin
                        r_s_old[r_cur][c] <= w_new[c];
                    end
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (i_led_ready) begin
                        o_led_valid <= 1'b0;
                        if (o_led_last) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_cur   <= r_cur + IDX_W'(1);
                            r_state <= ST_LOAD;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/led_zone_averager.sv
// Per-LED window match and accumulation of the pixel stream; averages are handed
// to led_stream_out at frame end.
module led_zone_averager
    import amb_pkg::*;
#(
    parameter int H_PIX        = 1920,
    parameter int V_PIX        = 1080,
    parameter int NUM_H        = 19,
    parameter int NUM_V        = 11,
    parameter int WIN_LOG2     = 3,
    parameter int COLOR_W      = 8,
    parameter int SMOOTH_SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3*COLOR_W-1:0] i_rgb,
    input  logic [15:0]          i_h_cnt,
    input  logic [15:0]          i_v_cnt,
    input  logic                 i_v_sync,
    input  logic                 i_p_valid,
    output logic [3*COLOR_W-1:0] o_led_rgb,
    output logic [7:0]           o_led_idx,
    output logic                 o_led_last,
    output logic                 o_led_valid,
    input  logic                 i_led_ready,
    output logic [15:0]          o_frames_dropped
);

    localparam int NUM_LEDS = num_leds(NUM_H, NUM_V);
    localparam int W        = 1 << WIN_LOG2;
    localparam int SUM_W    = COLOR_W + 2 * WIN_LOG2;

    if ((W > H_PIX / NUM_H) || (W > V_PIX / NUM_V) || (NUM_LEDS > 255)) begin : g_geom_chk
        $error("led_zone_averager: window larger than zone or too many LEDs");
    end

    logic [NUM_LEDS-1:0]           w_hit_vec;
    logic                          w_hit;
    logic [7:0]                    w_id;
    logic                          w_vs_fall;
    logic                          w_frame_end;
    logic [NUM_LEDS*3*COLOR_W-1:0] w_avg_flat;
    logic                          r_vs_d;
    logic                          r_s1_hit;
    logic [7:0]                    r_s1_id;
    logic [3*COLOR_W-1:0]          r_s1_rgb;
    logic [SUM_W-1:0]              r_sum [NUM_LEDS][3];

    // Wrapping 17-bit offsets make "below origin" land far outside the window.
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_win
        localparam win_org_t ORG = win_origin(gi, H_PIX, V_PIX, NUM_H, NUM_V, W);
        logic [16:0] w_dx;
        logic [16:0] w_dy;
        assign w_dx = {1'b0, i_h_cnt} - {1'b0, ORG.x};
        assign w_dy = {1'b0, i_v_cnt} - {1'b0, ORG.y};
        assign w_hit_vec[gi] = (w_dx < 17'(W)) && (w_dy < 17'(W));
        for (genvar gc = 0; gc < 3; gc++) begin : g_ch
            assign w_avg_flat[(gi*3+gc)*COLOR_W +: COLOR_W] = r_sum[gi][gc][SUM_W-1 -: COLOR_W];
        end
    end

    always_comb begin
        w_hit = 1'b0;
        w_id  = 8'd0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (w_hit_vec[i]) begin
                w_hit = 1'b1;
                w_id  = 8'(i);
            end
        end
    end

    assign w_vs_fall   = r_vs_d & ~i_v_sync;
    assign w_frame_end = i_v_sync & ~r_vs_d;

    // r_vs_d resets high so leaving reset inside blanking is not taken as a frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs_d   <= 1'b1;
            r_s1_hit <= 1'b0;
            r_s1_id  <= '0;
            r_s1_rgb <= '0;
        end else begin
            r_vs_d   <= i_v_sync;
            r_s1_hit <= i_p_valid & w_hit;
            r_s1_id  <= w_id;
            r_s1_rgb <= i_rgb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LEDS; i++)
                for (int c = 0; c < 3; c++) r_sum[i][c] <= '0;
        end else if (w_vs_fall) begin
            for (int i = 0; i < NUM_LEDS; i++)
                for (int c = 0; c < 3; c++) r_sum[i][c] <= '0;
        end else if (r_s1_hit) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (r_s1_id == 8'(i)) begin
                    for (int c = 0; c < 3; c++) begin
                        r_sum[i][c] <= r_sum[i][c] +
                            {{(2*WIN_LOG2){1'b0}}, r_s1_rgb[(2-c)*COLOR_W +: COLOR_W]};
                    end
                end
            end
        end
    end

    led_stream_out #(
        .NUM_LEDS     (NUM_LEDS),
        .COLOR_W      (COLOR_W),
        .SMOOTH_SHIFT (SMOOTH_SHIFT)
    ) u_stream_out (
        .clk              (clk),
        .rst              (rst),
        .i_frame_end      (w_frame_end),
        .i_avgs           (w_avg_flat),
        .i_led_ready      (i_led_ready),
        .o_led_rgb        (o_led_rgb),
        .o_led_idx        (o_led_idx),
        .o_led_last       (o_led_last),
        .o_led_valid      (o_led_valid),
        .o_frames_dropped (o_frames_dropped)
    );

endmodule

// File: tb/tb_led_zone_averager.sv
// Directed bench: 64x32 frame, 6 LEDs, 4x4 windows; u0 unsmoothed, u1 with shift 1.
module tb_led_zone_averager;

    localparam int H  = 64;
    localparam int V  = 32;
    localparam int NH = 4;
    localparam int NV = 2;
    localparam int WL = 2;
    localparam int CW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] rgb;
    logic [15:0] h_cnt, v_cnt;
    logic        v_sync, p_valid;
    logic        ready0, ready1;
    logic [23:0] rgb0, rgb1;
    logic [7:0]  idx0, idx1;
    logic        last0, last1, valid0, valid1;
    logic [15:0] drop0, drop1;

    int n_checks = 0;
    int n_errors = 0;
    int rmode    = 0;
    int cyc      = 0;
    logic man_ready = 1'b1;

    logic [23:0] q_rgb0 [$];
    logic [7:0]  q_idx0 [$];
    logic        q_last0[$];
    logic [23:0] q_rgb1 [$];

    // window origins (0,28) (0,0) (22,0) (38,0) (60,0) (60,28); mode 3 pixel = {x, y, 0x11}
    logic [23:0] exp3 [6] = '{24'h011D11, 24'h010111, 24'h170111,
                              24'h270111, 24'h3D0111, 24'h3D1D11};

    always #5 clk = ~clk;

    led_zone_averager #(.H_PIX(H), .V_PIX(V), .NUM_H(NH), .NUM_V(NV),
                        .WIN_LOG2(WL), .COLOR_W(CW), .SMOOTH_SHIFT(0)) u0 (
        .clk(clk), .rst(rst), .i_rgb(rgb), .i_h_cnt(h_cnt), .i_v_cnt(v_cnt),
        .i_v_sync(v_sync), .i_p_valid(p_valid), .o_led_rgb(rgb0), .o_led_idx(idx0),
        .o_led_last(last0), .o_led_valid(valid0), .i_led_ready(ready0),
        .o_frames_dropped(drop0));

    led_zone_averager #(.H_PIX(H), .V_PIX(V), .NUM_H(NH), .NUM_V(NV),
                        .WIN_LOG2(WL), .COLOR_W(CW), .SMOOTH_SHIFT(1)) u1 (
        .clk(clk), .rst(rst), .i_rgb(rgb), .i_h_cnt(h_cnt), .i_v_cnt(v_cnt),
        .i_v_sync(v_sync), .i_p_valid(p_valid), .o_led_rgb(rgb1), .o_led_idx(idx1),
        .o_led_last(last1), .o_led_valid(valid1), .i_led_ready(ready1),
        .o_frames_dropped(drop1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int mode, input int x, input int y);
        case (mode)
            0:       return 24'h804020;
            1:       return (x == 0 && y == 31) ? 24'hFFFFFF : 24'h000000;
            2:       return 24'hFFFFFF;
            default: return {8'(x), 8'(y), 8'h11};
        endcase
    endfunction

    function automatic logic [23:0] exp_rgb(input int mode, input int k);
        case (mode)
            0:       return 24'h804020;
            1:       return (k == 0) ? 24'h0F0F0F : 24'h000000;
            2:       return 24'hFFFFFF;
            default: return exp3[k];
        endcase
    endfunction

    task automatic drive_frame(input int mode);
        @(posedge clk); #1;
        v_sync = 1'b0;
        p_valid = 1'b0;
        repeat (2) @(posedge clk);
        for (int yy = 0; yy < V; yy++) begin
            for (int xx = 0; xx < H; xx++) begin
                @(posedge clk); #1;
                p_valid = 1'b1;
                h_cnt   = 16'(xx);
                v_cnt   = 16'(yy);
                rgb     = pix(mode, xx, yy);
            end
        end
        @(posedge clk); #1;
        p_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 v_sync = 1'b1;
    endtask

    task automatic wait_q(input int n, input bit which);
        int t = 0;
        while (((which ? q_rgb1.size() : q_rgb0.size()) < n) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk(which ? "beat_cnt1" : "beat_cnt0", which ? q_rgb1.size() : q_rgb0.size(), n);
    endtask

    task automatic check_beats(input int base, input int mode);
        for (int k = 0; k < 6; k++) begin
            if (base + k < q_rgb0.size()) begin
                chk("beat_idx", q_idx0[base+k], k);
                chk("beat_rgb", q_rgb0[base+k], exp_rgb(mode, k));
                chk("beat_last", q_last0[base+k], (k == 5));
            end
        end
    endtask

    task automatic check_smooth(input int base, input logic [23:0] exp);
        for (int k = 0; k < 6; k++) begin
            if (base + k < q_rgb1.size()) chk("smooth_rgb", q_rgb1[base+k], exp);
        end
    endtask

    initial begin : ready_drv
        ready0 = 1'b1;
        ready1 = 1'b1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            case (rmode)
                0:       ready0 = 1'b1;
                1:       ready0 = (cyc % 3 == 0);
                default: ready0 = man_ready;
            endcase
        end
    end

    initial begin : monitor
        logic        stall;
        logic [31:0] held;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_valid", valid0, 1);
                    chk("hold_data", {idx0, rgb0}, held);
                end
                if (valid0 && ready0) begin
                    q_rgb0.push_back(rgb0);
                    q_idx0.push_back(idx0);
                    q_last0.push_back(last0);
                end
                if (valid1 && ready1) q_rgb1.push_back(rgb1);
                stall = valid0 && !ready0;
                held  = {idx0, rgb0};
            end
        end
    end

    initial begin : main
        int base;
        int base1;
        int lat;
        int t;
        rst = 1'b1; rgb = '0; h_cnt = '0; v_cnt = '0; v_sync = 1'b1; p_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid0, 0);
        chk("rst_idx", idx0, 0);
        chk("rst_rgb", rgb0, 0);
        chk("rst_last", last0, 0);
        chk("rst_drop", drop0, 0);
        rst = 1'b0;

        // two saturated frames: smoothing walks 0 -> 0x7F -> 0xBF
        drive_frame(2);
        wait_q(6, 1'b0);
        wait_q(6, 1'b1);
        check_beats(0, 2);
        check_smooth(0, 24'h7F7F7F);
        drive_frame(2);
        wait_q(12, 1'b0);
        wait_q(12, 1'b1);
        check_beats(6, 2);
        check_smooth(6, 24'hBFBFBF);

        base = q_rgb0.size();
        drive_frame(0);
        lat = 0;
        while (!valid0 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 2);
        wait_q(base + 6, 1'b0);
        check_beats(base, 0);

        base = q_rgb0.size();
        drive_frame(1);
        wait_q(base + 6, 1'b0);
        check_beats(base, 1);

        rmode = 1;
        base = q_rgb0.size();
        drive_frame(3);
        wait_q(base + 6, 1'b0);
        check_beats(base, 3);
        repeat (4) @(negedge clk);

        // second frame ends while idx 2 is stalled
        rmode = 2;
        man_ready = 1'b1;
        base = q_rgb0.size();
        base1 = q_rgb1.size();
        drive_frame(3);
        t = 0;
        while (q_rgb0.size() < base + 2 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        man_ready = 1'b0;
        chk("drop_pre_beats", q_rgb0.size(), base + 2);
        drive_frame(0);
        repeat (2) @(negedge clk);
        chk("drop_cnt", drop0, 1);
        chk("drop_valid", valid0, 1);
        chk("drop_idx", idx0, 2);
        chk("drop_cnt_u1", drop1, 0);
        man_ready = 1'b1;
        wait_q(base + 6, 1'b0);
        check_beats(base, 3);
        wait_q(base1 + 12, 1'b1);
        repeat (4) @(negedge clk);

        // reset while a beat is pending
        man_ready = 1'b0;
        drive_frame(0);
        t = 0;
        while (!valid0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("pre_rst_valid", valid0, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", valid0, 0);
        chk("midrst_idx", idx0, 0);
        chk("midrst_rgb", rgb0, 0);
        chk("midrst_last", last0, 0);
        chk("midrst_drop", drop0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rmode = 0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", valid0, 0);
        base = q_rgb0.size();
        drive_frame(3);
        wait_q(base + 6, 1'b0);
        check_beats(base, 3);
        chk("post_rst_drop", drop0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
